// File: rtl/ntwrk_topk_reducer.sv
// ============================================================================
// Module   : ntwrk_topk_reducer
// Brief    : Keeps the TOP_K largest network sizes from a stream and reduces
//            them, one slot per cycle, to a product or sum answer.
//            Optional build macro: NTWRK_TOPK_CYCLE_CNT_EN (adds cycle_cnt).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntwrk_topk_reducer #(
  parameter int SZ_W     = 10,
  parameter int TOP_K    = 3,
  parameter int ANSWER_W = 30,
  parameter int MODE     = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SZ_W-1:0]     sz_in,
  input  logic                sz_in_vld,
  input  logic                sz_in_last,
  output logic                sz_in_rdy,
  output logic [ANSWER_W-1:0] answer,
  output logic                answer_ovf,
  output logic                answer_vld,
  input  logic                answer_rdy
`ifdef NTWRK_TOPK_CYCLE_CNT_EN
  ,
  output logic [63:0]         cycle_cnt
`endif
);

  localparam logic [1:0] c_st_collect = 2'd0;
  localparam logic [1:0] c_st_reduce  = 2'd1;
  localparam logic [1:0] c_st_done    = 2'd2;
  localparam int c_idx_w  = $clog2(TOP_K) + 1;
  localparam int c_full_w = ANSWER_W + SZ_W;
  localparam logic [ANSWER_W-1:0] c_acc_init = (MODE == 0) ? ANSWER_W'(1) : '0;

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic [SZ_W-1:0]     r_slot [TOP_K];
  logic [SZ_W-1:0]     w_ins  [TOP_K];
  logic [TOP_K-1:0]    w_gt;
  logic [c_idx_w-1:0]  r_idx;
  logic [ANSWER_W-1:0] r_acc;
  logic                r_ovf;
  logic [ANSWER_W-1:0] r_answer;
  logic                r_answer_ovf;
  logic [c_full_w-1:0] w_full;
  logic [ANSWER_W-1:0] w_acc_nxt;
  logic                w_ovf_nxt;
  logic                w_accept;
  logic                w_last_slot;

  assign w_accept    = (r_state == c_st_collect) && sz_in_vld;
  assign w_last_slot = (r_idx == c_idx_w'(TOP_K - 1));

  // Sorted insert: w_gt is monotonic over a descending list, so the first set
  // bit marks the insertion point and every later slot takes its predecessor.
  genvar gi;
  generate
    for (gi = 0; gi < TOP_K; gi++) begin : g_ins
      assign w_gt[gi] = (sz_in > r_slot[gi]);
      if (gi == 0) begin : g_head
        assign w_ins[gi] = w_gt[gi] ? sz_in : r_slot[gi];
      end else begin : g_tail
        assign w_ins[gi] = w_gt[gi-1] ? r_slot[gi-1] : (w_gt[gi] ? sz_in : r_slot[gi]);
      end
    end
  endgenerate

  always_comb begin
    if (MODE == 0) w_full = c_full_w'(r_acc) * c_full_w'(r_slot[0]);
    else           w_full = c_full_w'(r_acc) + c_full_w'(r_slot[0]);
    if (r_slot[0] == '0) begin
      w_acc_nxt = r_acc;
      w_ovf_nxt = r_ovf;
    end else begin
      w_acc_nxt = w_full[ANSWER_W-1:0];
      w_ovf_nxt = r_ovf | (|w_full[c_full_w-1:ANSWER_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_st_collect;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_collect: if (w_accept && sz_in_last) w_next = c_st_reduce;
      c_st_reduce:  if (w_last_slot)            w_next = c_st_done;
      c_st_done:    if (answer_rdy)             w_next = c_st_collect;
      default:                                  w_next = c_st_collect;
    endcase
  end

  always_comb begin
    sz_in_rdy  = (r_state == c_st_collect);
    answer_vld = (r_state == c_st_done);
    answer     = r_answer;
    answer_ovf = r_answer_ovf;
  end

  // Reduction consumes slot[0] and shifts the list up, leaving it empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TOP_K; i++) r_slot[i] <= '0;
    end else begin
      case (r_state)
        c_st_collect: if (w_accept) for (int i = 0; i < TOP_K; i++) r_slot[i] <= w_ins[i];
        c_st_reduce: begin
          for (int i = 0; i < TOP_K - 1; i++) r_slot[i] <= r_slot[i+1];
          r_slot[TOP_K-1] <= '0;
        end
        c_st_done: if (answer_rdy) for (int i = 0; i < TOP_K; i++) r_slot[i] <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_acc        <= '0;
      r_ovf        <= 1'b0;
      r_answer     <= '0;
      r_answer_ovf <= 1'b0;
    end else if (r_state == c_st_collect) begin
      if (w_accept && sz_in_last) begin
        r_idx <= '0;
        r_acc <= c_acc_init;
        r_ovf <= 1'b0;
      end
    end else if (r_state == c_st_reduce) begin
      r_idx <= r_idx + c_idx_w'(1);
      r_acc <= w_acc_nxt;
      r_ovf <= w_ovf_nxt;
      if (w_last_slot) begin
        r_answer     <= w_acc_nxt;
        r_answer_ovf <= w_ovf_nxt;
      end
    end
  end

`ifdef NTWRK_TOPK_CYCLE_CNT_EN
  logic        r_cnt_run;
  logic [63:0] r_cycle_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt_run   <= 1'b0;
      r_cycle_cnt <= '0;
    end else if ((r_state == c_st_done) && answer_rdy) begin
      r_cnt_run   <= 1'b0;
      r_cycle_cnt <= '0;
    end else if (r_cnt_run || w_accept) begin
      r_cycle_cnt <= r_cycle_cnt + 64'd1;
      r_cnt_run   <= !((r_state == c_st_reduce) && w_last_slot);
    end
  end

  assign cycle_cnt = r_cycle_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ntwrk_topk_reducer.sv
// ============================================================================
// Module   : tb_ntwrk_topk_reducer
// Brief    : Scoreboard bench for three configurations: product, sum and a
//            narrow-answer overflow build.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ntwrk_topk_reducer;

  typedef struct {
    logic [29:0] ans;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  sz   [3];
  logic        vld  [3];
  logic        lst  [3];
  logic        arsp [3];
  logic        rdy  [3];
  logic        avld [3];
  logic        aovf [3];
  logic [29:0] ans0, ans1;
  logic [15:0] ans2;
`ifdef NTWRK_TOPK_CYCLE_CNT_EN
  logic [63:0] cc [3];
`endif

  int      n_assert = 0;
  int      n_fail   = 0;
  longint  cyc      = 0;
  longint  t_acc    = 0;
  int      stim[$];
  exp_t    sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ntwrk_topk_reducer u_prod (
    .clk(clk), .rst_n(rst_n), .sz_in(sz[0]), .sz_in_vld(vld[0]), .sz_in_last(lst[0]),
    .sz_in_rdy(rdy[0]), .answer(ans0), .answer_ovf(aovf[0]), .answer_vld(avld[0]),
    .answer_rdy(arsp[0])
`ifdef NTWRK_TOPK_CYCLE_CNT_EN
    , .cycle_cnt(cc[0])
`endif
  );

  ntwrk_topk_reducer #(.MODE(1)) u_sum (
    .clk(clk), .rst_n(rst_n), .sz_in(sz[1]), .sz_in_vld(vld[1]), .sz_in_last(lst[1]),
    .sz_in_rdy(rdy[1]), .answer(ans1), .answer_ovf(aovf[1]), .answer_vld(avld[1]),
    .answer_rdy(arsp[1])
`ifdef NTWRK_TOPK_CYCLE_CNT_EN
    , .cycle_cnt(cc[1])
`endif
  );

  ntwrk_topk_reducer #(.SZ_W(8), .ANSWER_W(16)) u_ovf (
    .clk(clk), .rst_n(rst_n), .sz_in(sz[2][7:0]), .sz_in_vld(vld[2]), .sz_in_last(lst[2]),
    .sz_in_rdy(rdy[2]), .answer(ans2), .answer_ovf(aovf[2]), .answer_vld(avld[2]),
    .answer_rdy(arsp[2])
`ifdef NTWRK_TOPK_CYCLE_CNT_EN
    , .cycle_cnt(cc[2])
`endif
  );

  function automatic logic [29:0] get_ans(input int d);
    case (d)
      0:       return ans0;
      1:       return ans1;
      default: return {14'd0, ans2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: sort the nonzero sizes descending, reduce the top three with
  // wide arithmetic, flag any result that leaves the answer width.
  function automatic exp_t model(input int d);
    int     v[$];
    int     p;
    longint acc;
    longint mask;
    int     w;
    exp_t   e;
    w    = (d == 2) ? 16 : 30;
    mask = (longint'(1) << w) - 1;
    foreach (stim[i]) begin
      if (stim[i] != 0) begin
        p = v.size();
        for (int j = 0; j < v.size(); j++) begin
          if (v[j] < stim[i]) begin
            p = j;
            break;
          end
        end
        v.insert(p, stim[i]);
      end
    end
    acc   = (d == 1) ? 0 : 1;
    e.ovf = 1'b0;
    for (int i = 0; i < 3 && i < v.size(); i++) begin
      if (d == 1) acc = acc + v[i];
      else        acc = acc * v[i];
      if ((acc >> w) != 0) e.ovf = 1'b1;
      acc = acc & mask;
    end
    e.ans = 30'(acc);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge right after the last accept.
  task automatic send(input int d, input bit complete);
    for (int i = 0; i < stim.size(); i++) begin
      for (int g = 0; g < 50 && rdy[d] !== 1'b1; g++) @(negedge clk);
      if (rdy[d] !== 1'b1) check("sz_in_rdy wait", 64'(rdy[d]), 64'd1);
      sz[d]  = 10'(stim[i]);
      vld[d] = 1'b1;
      lst[d] = (i == stim.size() - 1);
      @(negedge clk);
      t_acc  = cyc;
      vld[d] = 1'b0;
      lst[d] = 1'b0;
    end
    if (complete) sb.push_back(model(d));
  endtask

  task automatic finish(input int d);
    exp_t e;
    check("reduce rdy low", 64'(rdy[d]), 64'd0);
    while (avld[d] !== 1'b1 && (cyc - t_acc) < 20) @(negedge clk);
    check("answer latency", 64'(cyc - t_acc), 64'd3);
    check("answer_vld", 64'(avld[d]), 64'd1);
    if (sb.size() == 0) begin
      check("scoreboard empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check("answer", 64'(get_ans(d)), 64'(e.ans));
      check("answer_ovf", 64'(aovf[d]), 64'(e.ovf));
    end
    if (arsp[d] === 1'b1) begin
      @(negedge clk);
      check("vld drop", 64'(avld[d]), 64'd0);
      check("rdy return", 64'(rdy[d]), 64'd1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      sz[d] = '0; vld[d] = 1'b0; lst[d] = 1'b0; arsp[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset rdy", 64'(rdy[d]), 64'd1);
      check("reset vld", 64'(avld[d]), 64'd0);
      check("reset answer", 64'(get_ans(d)), 64'd0);
      check("reset ovf", 64'(aovf[d]), 64'd0);
    end

    stim = '{5, 2, 9, 4, 7};   send(0, 1); finish(0);
    stim = '{6, 6, 0};         send(0, 1); finish(0);
    stim = '{8};               send(0, 1); finish(0);
    stim = '{0};               send(0, 1); finish(0);

    stim = '{3, 10, 1, 10};    send(1, 1); finish(1);
    stim = '{0};               send(1, 1); finish(1);

    stim = '{255, 255, 255};   send(2, 1); finish(2);
    stim = '{2, 3};            send(2, 1); finish(2);

    // Backpressure: answer held while extra beats are offered and ignored.
    arsp[0] = 1'b0;
    stim = '{2, 3};            send(0, 1); finish(0);
    for (int i = 0; i < 20; i++) begin
      sz[0] = 10'd1000; vld[0] = 1'b1; lst[0] = 1'b1;
      @(negedge clk);
      check("bp vld", 64'(avld[0]), 64'd1);
      check("bp answer", 64'(ans0), 64'd6);
      check("bp rdy", 64'(rdy[0]), 64'd0);
    end
    vld[0] = 1'b0; lst[0] = 1'b0; arsp[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp release vld", 64'(avld[0]), 64'd0);
    check("bp release rdy", 64'(rdy[0]), 64'd1);
    check("answer kept", 64'(ans0), 64'd6);
    stim = '{3};               send(0, 1); finish(0);

    // Reset during the second reduce cycle discards the stream.
    stim = '{3, 7};            send(0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post-reset vld", 64'(avld[0]), 64'd0);
    end
    check("post-reset answer", 64'(ans0), 64'd0);
    check("post-reset ovf", 64'(aovf[0]), 64'd0);
    check("post-reset rdy", 64'(rdy[0]), 64'd1);
    stim = '{4, 5};            send(0, 1); finish(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
